// File: rtl/id_stage_sb.sv
// id_stage_sb: venus decode stage with bypassed register file, valid handshake and load-use scoreboard
module id_stage_sb #(
  parameter int DATA_W = 32,
  parameter int NREG = 16,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              inst_v_i,
  input  logic              stall_i,
  output logic              stall_o,
  input  logic              wb_i,
  input  logic [3:0]        wb_r_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              v_o,
  output logic [6:0]        opcode_o,
  output logic [3:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_value_o,
  output logic [DATA_W-1:0] rs_value_o,
  output logic [DATA_W-1:0] imm_value_o,
  output logic              immf_o,
  output logic              ctrl_inte_o,
  output logic              ctrl_logic_o,
  output logic              ctrl_shift_o,
  output logic              ctrl_ld_o,
  output logic              ctrl_st_o,
  output logic              ctrl_br_o
);
  localparam logic [4:0] NR = 5'(NREG);
  logic [6:0] op;
  logic immf;
  logic [3:0] rd, rs;
  logic [15:0] imm;
  logic [2:0] cls;
  logic [DATA_W-1:0] rf [16];
  logic [15:0] pend;
  logic wr, use_rs, use_rd, hazard, issue, ld_issue;
  logic [DATA_W-1:0] rd_val, rs_val, imm_val;
  logic [5:0] ctrl_d, ctrl_q;
  assign {op, immf, rd, rs, imm} = inst_i;
  assign cls = op[6:4];
  assign wr = wb_i & ({1'b0, wb_r_i} < NR);
  assign rd_val = ({1'b0, rd} >= NR) ? '0 : (wr && wb_r_i == rd) ? wb_data_i : rf[rd];
  assign rs_val = ({1'b0, rs} >= NR) ? '0 : (wr && wb_r_i == rs) ? wb_data_i : rf[rs];
  assign imm_val = IMM_SEXT ? DATA_W'($signed(imm)) : DATA_W'(imm);
  assign ctrl_d = (cls < 3'd6) ? 6'd1 << cls : 6'd0;
  assign use_rs = ~immf;
  assign use_rd = (cls < 3'd6) & (cls != 3'd3);
  assign hazard = inst_v_i & ((use_rs & pend[rs] & ~(wr & (wb_r_i == rs))) |
                              (use_rd & pend[rd] & ~(wr & (wb_r_i == rd))));
  assign stall_o = stall_i | hazard;
  assign issue = inst_v_i & ~stall_o;
  assign ld_issue = issue & (cls == 3'd3) & ({1'b0, rd} < NR);
  assign {ctrl_br_o, ctrl_st_o, ctrl_ld_o, ctrl_shift_o, ctrl_logic_o, ctrl_inte_o} = ctrl_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rf <= '{default: '0};
      pend <= '0;
      v_o <= 1'b0;
      ctrl_q <= '0;
      opcode_o <= '0;
      rd_addr_o <= '0;
      rd_value_o <= '0;
      rs_value_o <= '0;
      imm_value_o <= '0;
      immf_o <= 1'b0;
    end else begin
      if (wr) rf[wb_r_i] <= wb_data_i;
      pend <= (pend & ~(wr ? 16'd1 << wb_r_i : 16'd0)) | (ld_issue ? 16'd1 << rd : 16'd0);
      if (!stall_i) begin
        v_o <= issue;
        ctrl_q <= issue ? ctrl_d : 6'd0;
        if (issue) begin
          opcode_o <= op;
          rd_addr_o <= rd;
          rd_value_o <= rd_val;
          rs_value_o <= rs_val;
          imm_value_o <= imm_val;
          immf_o <= immf;
        end
      end
    end
endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb: directed checks of id_stage_sb, default build plus an NREG=8 / zero-extend build
module tb_id_stage_sb;
  logic clk = 1'b0, rst = 1'b0, inst_v_i = 1'b0, stall_i = 1'b0, wb_i = 1'b0;
  logic [31:0] inst_i = '0, wb_data_i = '0;
  logic [3:0] wb_r_i = '0;
  logic stall_o, v_o, immf_o, c0, c1, c2, c3, c4, c5;
  logic [6:0] opcode_o;
  logic [3:0] rd_addr_o;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic stall2, v2, immf2, d0, d1, d2, d3, d4, d5;
  logic [6:0] opcode2;
  logic [3:0] rd_addr2;
  logic [31:0] rd_value2, rs_value2, imm_value2;
  logic [5:0] ctrl, ctrl2;
  int errors = 0, checks = 0;
  assign ctrl = {c5, c4, c3, c2, c1, c0};
  assign ctrl2 = {d5, d4, d3, d2, d1, d0};
  always #5 clk = ~clk;
  id_stage_sb dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_v_i(inst_v_i), .stall_i(stall_i), .stall_o(stall_o),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i), .v_o(v_o), .opcode_o(opcode_o),
    .rd_addr_o(rd_addr_o), .rd_value_o(rd_value_o), .rs_value_o(rs_value_o), .imm_value_o(imm_value_o),
    .immf_o(immf_o), .ctrl_inte_o(c0), .ctrl_logic_o(c1), .ctrl_shift_o(c2), .ctrl_ld_o(c3),
    .ctrl_st_o(c4), .ctrl_br_o(c5)
  );
  id_stage_sb #(.DATA_W(32), .NREG(8), .IMM_SEXT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_v_i(inst_v_i), .stall_i(stall_i), .stall_o(stall2),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i), .v_o(v2), .opcode_o(opcode2),
    .rd_addr_o(rd_addr2), .rd_value_o(rd_value2), .rs_value_o(rs_value2), .imm_value_o(imm_value2),
    .immf_o(immf2), .ctrl_inte_o(d0), .ctrl_logic_o(d1), .ctrl_shift_o(d2), .ctrl_ld_o(d3),
    .ctrl_st_o(d4), .ctrl_br_o(d5)
  );
  function automatic logic [31:0] mk(logic [6:0] op, logic f, logic [3:0] rd, logic [3:0] rs, logic [15:0] imm);
    return {op, f, rd, rs, imm};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [6:0] op;
    logic [5:0] exp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v", v_o, 0);
    chk("rst_op", opcode_o, 0);
    chk("rst_rd", rd_value_o, 0);
    chk("rst_rs", rs_value_o, 0);
    chk("rst_imm", imm_value_o, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_stall", stall_o, 0);
    rst = 1'b1;
    inst_i = mk(7'h70, 0, 0, 0, 0); inst_v_i = 1;
    cyc();
    chk("nop_v", v_o, 1);
    chk("nop_ctrl", ctrl, 0);
    chk("nop_op", opcode_o, 7'h70);
    inst_v_i = 0; wb_i = 1; wb_r_i = 3; wb_data_i = 32'hDEADBEEF;
    cyc();
    chk("bubble_v", v_o, 0);
    wb_i = 0; inst_i = mk(7'h00, 0, 3, 3, 0); inst_v_i = 1;
    #1 chk("rf_stall", stall_o, 0);
    cyc();
    chk("rf_rd", rd_value_o, 32'hDEADBEEF);
    chk("rf_rs", rs_value_o, 32'hDEADBEEF);
    chk("rf_ctrl", ctrl, 6'b000001);
    chk("rf_rdaddr", rd_addr_o, 3);
    wb_i = 1; wb_r_i = 4; wb_data_i = 32'hCAFEF00D; inst_i = mk(7'h00, 0, 4, 4, 0);
    cyc();
    chk("byp_rd", rd_value_o, 32'hCAFEF00D);
    chk("byp_rs", rs_value_o, 32'hCAFEF00D);
    wb_i = 0; inst_i = mk(7'h10, 1, 1, 0, 16'h8001);
    cyc();
    chk("imm_sext", imm_value_o, 32'hFFFF8001);
    chk("imm_zext", imm_value2, 32'h00008001);
    chk("imm_f", immf_o, 1);
    chk("imm_ctrl", ctrl, 6'b000010);
    inst_i = mk(7'h30, 1, 5, 0, 0);
    cyc();
    chk("ld_ctrl", ctrl, 6'b001000);
    inst_i = mk(7'h00, 0, 0, 5, 0);
    #1 chk("lu_stall0", stall_o, 1);
    cyc();
    chk("lu_v0", v_o, 0);
    chk("lu_ctrl0", ctrl, 0);
    chk("lu_stall1", stall_o, 1);
    cyc();
    chk("lu_v1", v_o, 0);
    wb_i = 1; wb_r_i = 5; wb_data_i = 32'h12345678;
    #1 chk("lu_wb_stall", stall_o, 0);
    cyc();
    chk("lu_v2", v_o, 1);
    chk("lu_rs", rs_value_o, 32'h12345678);
    chk("lu_rd", rd_value_o, 0);
    wb_i = 0; stall_i = 1; inst_i = mk(7'h40, 0, 2, 1, 16'h0042);
    #1 chk("si_stall", stall_o, 1);
    cyc();
    chk("si_v0", v_o, 1);
    chk("si_op0", opcode_o, 7'h00);
    cyc();
    chk("si_v1", v_o, 1);
    chk("si_op1", opcode_o, 7'h00);
    chk("si_rs1", rs_value_o, 32'h12345678);
    stall_i = 0;
    cyc();
    chk("st_v", v_o, 1);
    chk("st_op", opcode_o, 7'h40);
    chk("st_ctrl", ctrl, 6'b010000);
    chk("st_imm", imm_value_o, 32'h42);
    inst_v_i = 0;
    cyc();
    chk("st_once_v", v_o, 0);
    chk("st_once_ctrl", ctrl, 0);
    chk("st_hold_op", opcode_o, 7'h40);
    inst_i = mk(7'h30, 1, 6, 0, 0); inst_v_i = 1;
    cyc();
    inst_i = mk(7'h00, 0, 0, 6, 0);
    #1 chk("rs6_stall", stall_o, 1);
    cyc();
    chk("rs6_v", v_o, 0);
    rst = 0;
    #1;
    chk("mid_rst_op", opcode_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    #1 rst = 1;
    cyc();
    chk("post_rst_v", v_o, 1);
    chk("post_rst_ctrl", ctrl, 6'b000001);
    inst_v_i = 0; wb_i = 1; wb_r_i = 12; wb_data_i = 32'd5;
    cyc();
    wb_i = 0; inst_i = mk(7'h00, 0, 12, 12, 0); inst_v_i = 1;
    cyc();
    chk("n8_rd", rd_value2, 0);
    chk("n8_rs", rs_value2, 0);
    chk("n16_rd", rd_value_o, 5);
    wb_i = 1; wb_r_i = 15; wb_data_i = 0;
    for (int i = 0; i < 31; i++) begin
      op = 7'($urandom_range(0, 127));
      exp = (op[6:4] < 3'd6) ? 6'd1 << op[6:4] : 6'd0;
      inst_i = mk(op, 1, 15, 0, 0);
      cyc();
      chk($sformatf("sweep%0d_%0h", i, op), {v_o, ctrl}, {1'b1, exp});
    end
    inst_i = mk(7'h30, 1, 15, 0, 0);
    cyc();
    wb_i = 0; inst_i = mk(7'h00, 1, 15, 0, 0);
    #1 chk("setwins_stall", stall_o, 1);
    wb_i = 1;
    #1 chk("clr_stall", stall_o, 0);
    cyc();
    chk("clr_v", v_o, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
